// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cam_pkg
// Brief    : Shared state encoding and default widths for the CAM sequencers.
// Revision : 1.0
// ============================================================================
package cam_pkg;

  localparam int CAM_DATA_W    = 16;
  localparam int CAM_ADDR_HI_W = 5;
  localparam int CAM_ADDR_LO_W = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    SCAN      = 3'd2,
    WAIT_ACK  = 3'd3,
    VEC_DONE  = 3'd4,
    ALL_DONE  = 3'd5
  } cam_state_e;

endpackage
`default_nettype wire

// File: rtl/cam_ack_timer.sv
`default_nettype none
// ============================================================================
// Module   : cam_ack_timer
// Brief    : Loadable up-counter with enable and terminal-count flag.
// Revision : 1.0
// ============================================================================
module cam_ack_timer #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] terminal,
  output logic             tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tc = (r_count == terminal);

endmodule
`default_nettype wire

// File: rtl/cam_data_store_p.sv
`default_nettype none
// ============================================================================
// Module   : cam_data_store_p
// Brief    : Batch CAM write sequencer, one-hot chip walk with ack timeout.
// Revision : 1.0
// ============================================================================
module cam_data_store_p
  import cam_pkg::*;
#(
  parameter int DATA_W      = CAM_DATA_W,
  parameter int ADDR_HI_W   = CAM_ADDR_HI_W,
  parameter int ADDR_LO_W   = CAM_ADDR_LO_W,
  parameter int CNT_W       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                           CLK,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_HI_W-1:0]           cmp_addr_high,
  input  logic [CNT_W-1:0]               num_vectors,
  input  logic                           skip_zero,
  input  logic [DATA_W-1:0]              data_in,
  input  logic                           data_valid,
  output logic                           data_ready,
  input  logic                           write_ack,
  output logic [DATA_W-1:0]              chip_enable,
  output logic                           wr_bit,
  output logic [ADDR_HI_W+ADDR_LO_W-1:0] cmp_addr_reg,
  output logic                           busy,
  output logic                           done,
  output logic                           done_all,
  output logic                           timeout_err
);

  localparam int c_chip_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int c_tmr_w  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [c_tmr_w-1:0]  c_tmr_term = (ACK_TIMEOUT > 0) ? c_tmr_w'(ACK_TIMEOUT - 1) : '0;
  localparam logic [c_chip_w-1:0] c_last_chip = c_chip_w'(DATA_W - 1);
  localparam logic [DATA_W-1:0]   c_one = DATA_W'(1);

  cam_state_e            r_state, w_next;
  logic [ADDR_HI_W-1:0]  r_addr_high;
  logic [CNT_W-1:0]      r_num_vec;
  logic                  r_skip_zero;
  logic [CNT_W-1:0]      r_vec_idx;
  logic [DATA_W-1:0]     r_shadow;
  logic [c_chip_w-1:0]   r_chip_idx;
  logic                  r_timeout_err;

  logic w_tmr_load, w_tmr_en, w_tc;
  logic w_timeout, w_ack_evt, w_last_chip, w_skip, w_last_vec;

  cam_ack_timer #(.WIDTH(c_tmr_w)) u_ack_timer (
    .CLK      (CLK),
    .rst      (rst),
    .load     (w_tmr_load),
    .en       (w_tmr_en),
    .terminal (c_tmr_term),
    .tc       (w_tc)
  );

  // A timeout is only meaningful while waiting; an ack on the same edge wins.
  assign w_timeout   = (ACK_TIMEOUT != 0) && w_tc;
  assign w_ack_evt   = write_ack || w_timeout;
  assign w_last_chip = (r_chip_idx == c_last_chip);
  assign w_skip      = r_skip_zero && !r_shadow[r_chip_idx];
  assign w_last_vec  = (r_vec_idx == r_num_vec - 1'b1);

  assign cmp_addr_reg = {r_addr_high, ADDR_LO_W'(r_vec_idx)};
  assign timeout_err  = r_timeout_err;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    data_ready  = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    done_all    = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_en    = 1'b0;
    chip_enable = '0;
    wr_bit      = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = (num_vectors == '0) ? ALL_DONE : WAIT_DATA;
      end
      WAIT_DATA: begin
        data_ready = 1'b1;
        if (data_valid) w_next = SCAN;
      end
      SCAN: begin
        w_tmr_load = 1'b1;
        if (!w_skip)         w_next = WAIT_ACK;
        else if (w_last_chip) w_next = VEC_DONE;
      end
      WAIT_ACK: begin
        chip_enable = c_one << r_chip_idx;
        wr_bit      = r_shadow[r_chip_idx];
        w_tmr_en    = 1'b1;
        if (w_ack_evt) w_next = w_last_chip ? VEC_DONE : SCAN;
      end
      VEC_DONE: begin
        done   = 1'b1;
        w_next = w_last_vec ? ALL_DONE : WAIT_DATA;
      end
      ALL_DONE: begin
        done_all = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_addr_high   <= '0;
      r_num_vec     <= '0;
      r_skip_zero   <= 1'b0;
      r_vec_idx     <= '0;
      r_shadow      <= '0;
      r_chip_idx    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_addr_high   <= cmp_addr_high;
          r_num_vec     <= num_vectors;
          r_skip_zero   <= skip_zero;
          r_vec_idx     <= '0;
          r_timeout_err <= 1'b0;
        end
        WAIT_DATA: if (data_valid) begin
          r_shadow   <= data_in;
          r_chip_idx <= '0;
        end
        SCAN: if (w_skip && !w_last_chip) r_chip_idx <= r_chip_idx + 1'b1;
        WAIT_ACK: if (w_ack_evt) begin
          if (w_timeout && !write_ack) r_timeout_err <= 1'b1;
          if (!w_last_chip) r_chip_idx <= r_chip_idx + 1'b1;
        end
        VEC_DONE: if (!w_last_vec) r_vec_idx <= r_vec_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cam_data_store_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_data_store_p
// Brief    : Randomized self-checking bench with a transaction-level CAM model.
// Revision : 1.0
// ============================================================================
module tb_cam_data_store_p;

  localparam int TO = 15;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  cmp_addr_high = '0;
  logic [3:0]  num_vectors = '0;
  logic        skip_zero = 1'b0;
  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        write_ack = 1'b0;
  logic        data_ready, wr_bit, busy, done, done_all, timeout_err;
  logic [15:0] chip_enable;
  logic [9:0]  cmp_addr_reg;

  cam_data_store_p #(
    .DATA_W(16), .ADDR_HI_W(5), .ADDR_LO_W(5), .CNT_W(4), .ACK_TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .rst(rst), .start(start), .cmp_addr_high(cmp_addr_high),
    .num_vectors(num_vectors), .skip_zero(skip_zero), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .write_ack(write_ack),
    .chip_enable(chip_enable), .wr_bit(wr_bit), .cmp_addr_reg(cmp_addr_reg),
    .busy(busy), .done(done), .done_all(done_all), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    int   v;
    int   c;
    logic b;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] g_vec[16];
  int          g_to_vec  = -1;
  int          g_to_chip = -1;
  int          g_dly     = -1;

  function automatic int pick_dly();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return r % 4;
    if (r < 8) return TO - 1;
    if (r == 8) return TO;
    return 99;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {data_ready, busy, done, done_all, timeout_err, wr_bit}, 0);
    check({tag, "_en"}, chip_enable, 0);
    check({tag, "_addr"}, cmp_addr_reg, 0);
  endtask

  // One batch: the model lists every expected chip write from the data and
  // skip rule; the bench plays the loader and the CAM bank around the DUT.
  task automatic run_batch(input logic [4:0] ah, input int n, input logic skip, input int rst_chip);
    int cyc = 0, vi = 0, vdone = 0, prev = -1, zeros = 0, hold = 0, dly = 0;
    int last_done = -10, exp_dur = 0;
    logic [15:0] prev_en = '0;
    logic exp_err = 1'b0, cur_err = 1'b0;
    bit fin = 0;
    ev_t ev;

    exp_q.delete();
    for (int v = 0; v < n; v++)
      for (int c = 0; c < 16; c++)
        if (!(skip && !g_vec[v][c])) exp_q.push_back('{v, c, g_vec[v][c]});

    @(negedge CLK);
    cmp_addr_high = ah; num_vectors = 4'(n); skip_zero = skip; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    cmp_addr_high = 5'($urandom); num_vectors = 4'($urandom); skip_zero = 1'($urandom);

    for (int t = 0; t < 20000 && !fin; t++) begin
      if (t != 0) @(negedge CLK);
      cyc++;
      if (cyc == 1) begin
        check("ready_after_start", data_ready, n != 0);
        check("err_cleared", timeout_err, 0);
      end
      check("busy_in_batch", busy, 1);

      if (chip_enable != '0) begin
        if (prev_en == '0) begin
          if (exp_q.size() == 0) begin
            check("extra_enable", chip_enable, 0);
            ev = '{0, 0, 1'b0};
          end else begin
            ev = exp_q.pop_front();
          end
          check("en_onehot", $onehot(chip_enable), 1);
          check("en_chip", chip_enable, 32'h1 << ev.c);
          check("wr_bit", wr_bit, ev.b);
          check("addr", cmp_addr_reg, {ah, 5'(ev.v)});
          check("scan_gap", zeros, ev.c - prev);
          prev = ev.c; zeros = 0; hold = 0;
          if (ev.v == g_to_vec && ev.c == g_to_chip) dly = 99;
          else if (g_dly >= 0) dly = g_dly;
          else dly = pick_dly();
          if (dly >= TO) exp_err = 1'b1;
          exp_dur = (dly + 1 < TO) ? dly + 1 : TO;
          if (rst_chip == ev.c) begin
            rst = 1'b0;
            #1;
            check_reset_outputs("midop_reset");
            write_ack = 1'b0; data_valid = 1'b0;
            @(negedge CLK);
            check_reset_outputs("held_reset");
            rst = 1'b1;
            exp_q.delete();
            return;
          end
        end else begin
          hold++;
        end
        write_ack = (hold == dly);
      end else begin
        if (prev_en != '0) begin
          check("en_cycles", hold + 1, exp_dur);
          if (dly >= TO) cur_err = 1'b1;
        end
        zeros++;
        write_ack = ($urandom_range(0, 3) == 0);
      end
      prev_en = chip_enable;
      check("timeout_err_live", timeout_err, cur_err);

      if (done) begin
        check("done_after_last", zeros, 16 - prev);
        check("done_vec_events", (exp_q.size() == 0) || (exp_q[0].v > vdone), 1);
        vdone++;
        last_done = cyc;
      end
      if (done_all) begin
        check("done_all_timing", cyc, (n == 0) ? 1 : last_done + 1);
        check("done_count", vdone, n);
        check("events_left", exp_q.size(), 0);
        fin = 1;
      end

      if (data_ready) begin
        check("ready_expected", vi < n, 1);
        if ($urandom_range(0, 2) != 0 && vi < n) begin
          data_valid = 1'b1; data_in = g_vec[vi]; vi++;
          prev = -1; zeros = 0;
        end else begin
          data_valid = 1'b0; data_in = 16'($urandom);
        end
      end else begin
        data_valid = ($urandom_range(0, 3) == 0);
        data_in    = 16'($urandom);
      end
    end

    if (!fin) check("batch_bound", 0, 1);
    data_valid = 1'b0; write_ack = 1'b0;
    @(negedge CLK);
    check("idle_busy", busy, 0);
    check("idle_enable", chip_enable, 0);
    check("err_sticky", timeout_err, exp_err);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    rst = 1'b1;

    g_vec[0] = 16'hE26F; g_vec[1] = 16'hF89B; g_dly = 3;
    run_batch(5'b00001, 2, 1'b0, -1);
    run_batch(5'b00001, 1, 1'b1, -1);
    g_vec[0] = 16'h0000;
    run_batch(5'b00011, 1, 1'b1, -1);
    run_batch(5'b00111, 0, 1'b0, -1);

    g_vec[0] = 16'($urandom); g_vec[1] = 16'($urandom);
    g_dly = 2; g_to_vec = 0; g_to_chip = 4;
    run_batch(5'b00010, 2, 1'b0, -1);
    g_to_vec = -1; g_to_chip = -1;
    run_batch(5'b00100, 1, 1'b0, -1);

    g_dly = 1;
    run_batch(5'b01001, 2, 1'b0, 7);
    run_batch(5'b01010, 1, 1'b0, -1);

    g_dly = -1;
    for (int b = 0; b < 8; b++) begin
      for (int v = 0; v < 16; v++) g_vec[v] = 16'($urandom);
      if ($urandom_range(0, 3) == 0) g_vec[0] = 16'h0000;
      g_to_vec  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : -1;
      g_to_chip = $urandom_range(0, 15);
      run_batch(5'($urandom), $urandom_range(0, 4), 1'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
